// File: rtl/cnn_pkg.sv
// Shared types, mode constants and the requantise/saturate helper for the CNN output stage.
package cnn_pkg;

    localparam logic POOL_NONE = 1'b0;
    localparam logic POOL_MAX2 = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Arithmetic shift right (floor) then clamp into a signed out_w-bit range.
    function automatic logic signed [63:0] sat_requant(
        input logic signed [63:0] x,
        input int unsigned        shift,
        input int unsigned        out_w
    );
        logic signed [63:0] sh;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sh = x >>> shift;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (sh > hi) begin
            return hi;
        end
        if (sh < lo) begin
            return lo;
        end
        return sh;
    endfunction

endpackage

// File: rtl/relu_quant.sv
// Per-channel stage 1: optional ReLU, requantise with saturation, registered output.
module relu_quant
    import cnn_pkg::*;
#(
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned SHIFT  = 8
) (
    input  logic              clock_i,
    input  logic              reset_ni,
    input  logic              en_i,
    input  logic              relu_en_i,
    input  logic [ACC_W-1:0]  acc_i,
    output logic [DATA_W-1:0] q_o
);

    logic signed [63:0] ext_c;
    logic [DATA_W-1:0]  q_d;
    logic [DATA_W-1:0]  q_q;

    // Sign-extend, clamp negatives when ReLU is on, then requantise.
    always_comb begin
        ext_c = {{(64 - ACC_W){acc_i[ACC_W-1]}}, acc_i};
        if (relu_en_i && acc_i[ACC_W-1]) begin
            ext_c = '0;
        end
        q_d = DATA_W'(sat_requant(ext_c, SHIFT, DATA_W));
    end

    // Stage-1 register, loaded only on accepted beats.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            q_q <= '0;
        end else if (en_i) begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/relu_pool_writer.sv
// CNN output stage: ReLU/requantise, optional 2x2 max pool, output RAM write generation.
module relu_pool_writer
    import cnn_pkg::*;
#(
    parameter int unsigned NUM_CH           = 6,
    parameter int unsigned ACCUM_DATA_WIDTH = 32,
    parameter int unsigned DATA_WIDTH       = 16,
    parameter int unsigned FRAC_SHIFT       = 8,
    parameter int unsigned MAP_W            = 28,
    parameter int unsigned MAP_H            = 28,
    parameter int unsigned POOL_ADDR_WIDTH  = 10
) (
    input  logic                               clock_i,
    input  logic                               reset_ni,
    input  logic                               start_i,
    input  logic                               pool_en_i,
    input  logic                               relu_en_i,
    input  logic                               in_valid_i,
    input  logic [ACCUM_DATA_WIDTH*NUM_CH-1:0] in_data_i,
    output logic                               out_wren_o,
    output logic [POOL_ADDR_WIDTH-1:0]         out_addr_o,
    output logic [DATA_WIDTH*NUM_CH-1:0]       out_data_o,
    output logic                               busy_o,
    output logic                               done_o
);

    localparam int unsigned CW     = (MAP_W > 1) ? $clog2(MAP_W) : 1;
    localparam int unsigned RW     = (MAP_H > 1) ? $clog2(MAP_H) : 1;
    localparam int unsigned HALF_W = MAP_W / 2;
    localparam int unsigned HW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;
    localparam int unsigned OW     = DATA_WIDTH * NUM_CH;

    state_e                     state_q, state_d;
    logic                       flush_cnt_q, flush_cnt_d;
    logic                       pool_q, pool_d;
    logic                       relu_q, relu_d;
    logic [CW-1:0]              col_q, col_d;
    logic [RW-1:0]              row_q, row_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       beat_c;

    logic                       s1_valid_q;
    logic [CW-1:0]              s1_col_q;
    logic [RW-1:0]              s1_row_q;
    logic [DATA_WIDTH-1:0]      s1_data [NUM_CH];

    logic [DATA_WIDTH-1:0]      hold_q [NUM_CH];
    logic [DATA_WIDTH-1:0]      lb_q   [NUM_CH][HALF_W];
    logic [DATA_WIDTH-1:0]      h_c    [NUM_CH];
    logic [DATA_WIDTH-1:0]      p_c    [NUM_CH];
    logic [HW-1:0]              lb_idx;
    logic                       hold_we;
    logic                       lb_we;

    logic                       wren_q, wren_d;
    logic [POOL_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [OW-1:0]              data_q, data_d;

    // Frame sequencing, beat acceptance and raster counters.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        pool_d      = pool_q;
        relu_d      = relu_q;
        col_d       = col_q;
        row_d       = row_q;
        beat_c      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    pool_d  = pool_en_i;
                    relu_d  = relu_en_i;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            RUN: begin
                if (in_valid_i) begin
                    beat_c = 1'b1;
                    if (col_q == CW'(MAP_W - 1)) begin
                        col_d = '0;
                        if (row_q == RW'(MAP_H - 1)) begin
                            row_d       = '0;
                            state_d     = FLUSH;
                            flush_cnt_d = 1'b0;
                        end else begin
                            row_d = row_q + RW'(1);
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            FLUSH: begin
                if (flush_cnt_q) begin
                    state_d = DONE;
                end else begin
                    flush_cnt_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN) || (state_d == FLUSH);
        done_d = (state_d == DONE);
    end

    // State, mode and status registers.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= IDLE;
            flush_cnt_q <= 1'b0;
            pool_q      <= POOL_NONE;
            relu_q      <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            pool_q      <= pool_d;
            relu_q      <= relu_d;
            col_q       <= col_d;
            row_q       <= row_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Stage-1 per-channel ReLU and requantisation.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        relu_quant #(
            .ACC_W  (ACCUM_DATA_WIDTH),
            .DATA_W (DATA_WIDTH),
            .SHIFT  (FRAC_SHIFT)
        ) u_relu_quant (
            .clock_i   (clock_i),
            .reset_ni  (reset_ni),
            .en_i      (beat_c),
            .relu_en_i (relu_q),
            .acc_i     (in_data_i[k*ACCUM_DATA_WIDTH +: ACCUM_DATA_WIDTH]),
            .q_o       (s1_data[k])
        );
    end

    // Raster position travelling alongside the stage-1 data.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            s1_valid_q <= 1'b0;
            s1_col_q   <= '0;
            s1_row_q   <= '0;
        end else begin
            s1_valid_q <= beat_c;
            if (beat_c) begin
                s1_col_q <= col_q;
                s1_row_q <= row_q;
            end
        end
    end

    // Pooling maxima and write-stage next values.
    always_comb begin
        wren_d  = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        hold_we = 1'b0;
        lb_we   = 1'b0;
        lb_idx  = HW'(s1_col_q >> 1);
        for (int k = 0; k < NUM_CH; k++) begin
            h_c[k] = ($signed(s1_data[k]) > $signed(hold_q[k])) ? s1_data[k] : hold_q[k];
            p_c[k] = ($signed(h_c[k]) > $signed(lb_q[k][lb_idx])) ? h_c[k] : lb_q[k][lb_idx];
        end
        if (s1_valid_q) begin
            if (pool_q == POOL_MAX2) begin
                if (!s1_col_q[0]) begin
                    hold_we = 1'b1;
                end else if (!s1_row_q[0]) begin
                    lb_we = 1'b1;
                end else begin
                    wren_d = 1'b1;
                    addr_d = POOL_ADDR_WIDTH'(32'(s1_row_q >> 1) * HALF_W + 32'(s1_col_q >> 1));
                    for (int k = 0; k < NUM_CH; k++) begin
                        data_d[k*DATA_WIDTH +: DATA_WIDTH] = p_c[k];
                    end
                end
            end else begin
                wren_d = 1'b1;
                addr_d = POOL_ADDR_WIDTH'(32'(s1_row_q) * MAP_W + 32'(s1_col_q));
                for (int k = 0; k < NUM_CH; k++) begin
                    data_d[k*DATA_WIDTH +: DATA_WIDTH] = s1_data[k];
                end
            end
        end
    end

    // Horizontal-max hold and line buffer registers.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int k = 0; k < NUM_CH; k++) begin
                hold_q[k] <= '0;
                for (int j = 0; j < HALF_W; j++) begin
                    lb_q[k][j] <= '0;
                end
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (hold_we) begin
                    hold_q[k] <= s1_data[k];
                end
                if (lb_we) begin
                    lb_q[k][lb_idx] <= h_c[k];
                end
            end
        end
    end

    // Output write register.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wren_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            wren_q <= wren_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign out_wren_o = wren_q;
    assign out_addr_o = addr_q;
    assign out_data_o = data_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_relu_pool_writer.sv
// Self-checking bench for relu_pool_writer on a 2-channel 4x4 map.
module tb_relu_pool_writer;

    localparam int unsigned NCH  = 2;
    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 16;
    localparam int unsigned FS   = 8;
    localparam int unsigned MW   = 4;
    localparam int unsigned MH   = 4;
    localparam int unsigned PAW  = 10;
    localparam int unsigned NPIX = MW * MH;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic                pool_en;
    logic                relu_en;
    logic                in_valid;
    logic [AW*NCH-1:0]   in_data;
    logic                out_wren;
    logic [PAW-1:0]      out_addr;
    logic [DW*NCH-1:0]   out_data;
    logic                busy;
    logic                done;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [31:0]       stim [NPIX][NCH];
    int                beat_cyc [NPIX];
    int                wr_cyc [$];
    logic [PAW-1:0]    wr_addr [$];
    logic [DW*NCH-1:0] wr_data [$];
    int                done_cyc [$];
    logic              busy_at_done;

    relu_pool_writer #(
        .NUM_CH           (NCH),
        .ACCUM_DATA_WIDTH (AW),
        .DATA_WIDTH       (DW),
        .FRAC_SHIFT       (FS),
        .MAP_W            (MW),
        .MAP_H            (MH),
        .POOL_ADDR_WIDTH  (PAW)
    ) dut (
        .clock_i    (clk),
        .reset_ni   (rst_n),
        .start_i    (start),
        .pool_en_i  (pool_en),
        .relu_en_i  (relu_en),
        .in_valid_i (in_valid),
        .in_data_i  (in_data),
        .out_wren_o (out_wren),
        .out_addr_o (out_addr),
        .out_data_o (out_data),
        .busy_o     (busy),
        .done_o     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (out_wren) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(out_addr);
            wr_data.push_back(out_data);
        end
        if (done) begin
            done_cyc.push_back(cyc);
            busy_at_done = busy;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference requantisation: floor division by 2^FS, then clamp.
    function automatic longint ref_q(input logic [31:0] raw, input bit relu);
        longint v;
        longint f;
        v = longint'($signed(raw));
        if (relu && v < 0) v = 0;
        f = v / 256;
        if ((v % 256) != 0 && v < 0) f = f - 1;
        if (f > 32767) f = 32767;
        if (f < -32768) f = -32768;
        return f;
    endfunction

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 3))
            0:       return $urandom();
            1:       return 32'($urandom_range(0, 200000)) - 32'd100000;
            2:       return 32'h7FFF_0000 + 32'($urandom_range(0, 65535));
            default: return 32'h8000_0000 + 32'($urandom_range(0, 65535));
        endcase
    endfunction

    task automatic fill_random();
        for (int i = 0; i < NPIX; i++)
            for (int k = 0; k < NCH; k++)
                stim[i][k] = rand_val();
    endtask

    task automatic fill_pass_directed();
        for (int i = 0; i < NPIX; i++) begin
            stim[i][0] = 32'hFFFF_FE00;
            stim[i][1] = 32'(256 * i);
        end
    endtask

    task automatic drive_beat(input int i);
        in_valid    = 1'b1;
        in_data     = {stim[i][1], stim[i][0]};
        beat_cyc[i] = cyc;
    endtask

    // One frame: start pulse, all beats (optionally with gaps and a stray start), wait for done.
    task automatic run_frame(input bit pool, input bit relu, input bit gaps, input string tag);
        int t;
        wr_cyc.delete();
        wr_addr.delete();
        wr_data.delete();
        done_cyc.delete();
        @(negedge clk);
        start   = 1'b1;
        pool_en = pool;
        relu_en = relu;
        @(negedge clk);
        start   = 1'b0;
        pool_en = 1'($urandom());
        relu_en = 1'($urandom());
        chk({tag, "_busy_after_start"}, 64'(busy), 64'd1);
        for (int i = 0; i < NPIX; i++) begin
            drive_beat(i);
            @(negedge clk);
            if (gaps) begin
                in_valid = 1'b0;
                in_data  = {$urandom(), $urandom()};
                for (int g = 0; g < 3; g++) begin
                    start   = (i == 7 && g == 1);
                    pool_en = 1'($urandom());
                    relu_en = 1'($urandom());
                    @(negedge clk);
                end
                start = 1'b0;
            end
        end
        in_valid = 1'b0;
        in_data  = {$urandom(), $urandom()};
        t = 0;
        while (done_cyc.size() == 0 && t < 40) begin
            @(negedge clk);
            #1;
            t++;
        end
        repeat (3) @(negedge clk);
    endtask

    // Compare recorded writes against the frame-level model of the current stimulus.
    task automatic check_frame(input bit pool, input bit relu, input string tag);
        longint            q [NPIX][NCH];
        logic [PAW-1:0]    ea [NPIX];
        logic [DW*NCH-1:0] ed [NPIX];
        int                es [NPIX];
        int                n;
        longint            m;
        for (int i = 0; i < NPIX; i++)
            for (int k = 0; k < NCH; k++)
                q[i][k] = ref_q(stim[i][k], relu);
        n = 0;
        if (!pool) begin
            for (int i = 0; i < NPIX; i++) begin
                ea[n] = PAW'(i);
                ed[n] = '0;
                for (int k = 0; k < NCH; k++) ed[n][k*DW +: DW] = DW'(q[i][k]);
                es[n] = i;
                n++;
            end
        end else begin
            for (int pr = 0; pr < MH / 2; pr++) begin
                for (int pc = 0; pc < MW / 2; pc++) begin
                    ea[n] = PAW'(pr * (MW / 2) + pc);
                    ed[n] = '0;
                    for (int k = 0; k < NCH; k++) begin
                        m = q[2 * pr * MW + 2 * pc][k];
                        for (int dr = 0; dr < 2; dr++)
                            for (int dc = 0; dc < 2; dc++)
                                if (q[(2 * pr + dr) * MW + 2 * pc + dc][k] > m)
                                    m = q[(2 * pr + dr) * MW + 2 * pc + dc][k];
                        ed[n][k*DW +: DW] = DW'(m);
                    end
                    es[n] = (2 * pr + 1) * MW + 2 * pc + 1;
                    n++;
                end
            end
        end
        chk({tag, "_write_count"}, 64'(wr_addr.size()), 64'(n));
        for (int j = 0; j < n && j < wr_addr.size(); j++) begin
            chk($sformatf("%s_addr%0d", tag, j), 64'(wr_addr[j]), 64'(ea[j]));
            chk($sformatf("%s_data%0d", tag, j), 64'(wr_data[j]), 64'(ed[j]));
            chk($sformatf("%s_lat%0d", tag, j), 64'(wr_cyc[j] - beat_cyc[es[j]]), 64'd2);
        end
        chk({tag, "_done_count"}, 64'(done_cyc.size()), 64'd1);
        if (done_cyc.size() > 0 && wr_cyc.size() > 0) begin
            chk({tag, "_done_cycle"}, 64'(done_cyc[0]), 64'(wr_cyc[wr_cyc.size() - 1] + 1));
            chk({tag, "_busy_at_done"}, 64'(busy_at_done), 64'd0);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_wren"}, 64'(out_wren), 64'd0);
        chk({tag, "_addr"}, 64'(out_addr), 64'd0);
        chk({tag, "_data"}, 64'(out_data), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [DW*NCH-1:0] w;
        logic [DW-1:0]     pool_exp [4];

        // Reset with random activity including start pulses.
        rst_n    = 1'b0;
        start    = 1'b0;
        pool_en  = 1'b0;
        relu_en  = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            start    = 1'($urandom());
            pool_en  = 1'($urandom());
            relu_en  = 1'($urandom());
            in_valid = 1'($urandom());
            in_data  = {$urandom(), $urandom()};
            if (c == 1 || c == 3) begin
                #1;
                chk_outputs_zero($sformatf("reset%0d", c));
            end
        end
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_busy", 64'(busy), 64'd0);
        chk("post_reset_wren", 64'(out_wren), 64'd0);

        // Directed pass-through with ReLU.
        fill_pass_directed();
        run_frame(1'b0, 1'b1, 1'b0, "pass_dir");
        check_frame(1'b0, 1'b1, "pass_dir");

        // Saturation corners, no ReLU.
        fill_random();
        stim[0][0] = 32'h7FFF_FF00;
        stim[0][1] = 32'hFF00_0000;
        stim[1][1] = 32'hFFFF_FFFF;
        run_frame(1'b0, 1'b0, 1'b0, "sat");
        check_frame(1'b0, 1'b0, "sat");
        if (wr_data.size() > 1) begin
            w = wr_data[0];
            chk("sat_pos", 64'(w[DW-1:0]), 64'h7FFF);
            chk("sat_neg", 64'(w[2*DW-1:DW]), 64'h8000);
            w = wr_data[1];
            chk("sat_floor", 64'(w[2*DW-1:DW]), 64'hFFFF);
        end

        // Directed 2x2 pool with ReLU.
        for (int i = 0; i < NPIX; i++) begin
            stim[i][0] = 32'(256 * i);
            stim[i][1] = 32'(-(256 * i));
        end
        run_frame(1'b1, 1'b1, 1'b0, "pool_dir");
        check_frame(1'b1, 1'b1, "pool_dir");
        pool_exp[0] = 16'd5;
        pool_exp[1] = 16'd7;
        pool_exp[2] = 16'd13;
        pool_exp[3] = 16'd15;
        for (int j = 0; j < 4 && j < wr_data.size(); j++) begin
            w = wr_data[j];
            chk($sformatf("pool_const_ch0_%0d", j), 64'(w[DW-1:0]), 64'(pool_exp[j]));
            chk($sformatf("pool_const_ch1_%0d", j), 64'(w[2*DW-1:DW]), 64'd0);
        end

        // Random frames in each mode.
        fill_random();
        run_frame(1'b1, 1'b0, 1'b0, "pool_rand");
        check_frame(1'b1, 1'b0, "pool_rand");
        fill_random();
        run_frame(1'b0, 1'b0, 1'b0, "pass_rand");
        check_frame(1'b0, 1'b0, "pass_rand");

        // Same random pool frame without and with gaps plus a stray start.
        fill_random();
        run_frame(1'b1, 1'b1, 1'b0, "pool_nogap");
        check_frame(1'b1, 1'b1, "pool_nogap");
        run_frame(1'b1, 1'b1, 1'b1, "pool_gap");
        check_frame(1'b1, 1'b1, "pool_gap");

        // Abort after 5 beats, then a full rerun.
        fill_pass_directed();
        @(negedge clk);
        start   = 1'b1;
        pool_en = 1'b0;
        relu_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_beat(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        wr_cyc.delete();
        wr_addr.delete();
        wr_data.delete();
        done_cyc.delete();
        #1;
        chk_outputs_zero("abort");
        repeat (3) @(negedge clk);
        chk("abort_no_writes", 64'(wr_addr.size()), 64'd0);
        chk("abort_no_done", 64'(done_cyc.size()), 64'd0);
        rst_n = 1'b1;
        run_frame(1'b0, 1'b1, 1'b0, "after_abort");
        check_frame(1'b0, 1'b1, "after_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/relu_pool_writer.md
# relu_pool_writer

Parametrised output stage for a CNN convolution layer. It sits between the per-channel MAC accumulators and the per-channel output feature-map RAMs. For each accumulated pixel it applies optional ReLU and fixed-point requantisation with saturation. It then either writes every pixel directly or performs 2x2 max pooling, and generates the output-RAM write address and write enable. It replaces the fixed no-pool/ReLU pairing with run-time selectable modes, a generic channel count and generic map geometry.

## Interface
Parameters:
- NUM_CH, 6: channels processed in parallel (one output RAM each)
- ACCUM_DATA_WIDTH, 32: signed accumulator width per channel
- DATA_WIDTH, 16: signed output word width
- FRAC_SHIFT, 8: arithmetic right shift applied before saturation
- MAP_W, 28: input map width in pixels; must be even
- MAP_H, 28: input map height in pixels; must be even
- POOL_ADDR_WIDTH, 10: output address width; must satisfy 2^POOL_ADDR_WIDTH >= MAP_W*MAP_H

Ports:
- clock, in, 1: single clock, rising edge
- reset, in, 1: asynchronous, active-low reset
- start, in, 1: one-cycle frame start pulse; accepted only in IDLE
- pool_en, in, 1: 1 = 2x2 max pool, 0 = pass-through; sampled on accepted start
- relu_en, in, 1: 1 = clamp negatives to 0; sampled on accepted start
- in_valid, in, 1: one pixel, all channels, raster order
- in_data, in, ACCUM_DATA_WIDTH*NUM_CH: channel k occupies bits [k*ACCUM_DATA_WIDTH +: ACCUM_DATA_WIDTH]
- out_wren, out, 1: write strobe shared by all channel RAMs
- out_addr, out, POOL_ADDR_WIDTH: write address
- out_data, out, DATA_WIDTH*NUM_CH: channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
- busy, out, 1: high from accepted start until done
- done, out, 1: one-cycle pulse when the frame is complete

## Operation
- State machine:
  - IDLE -> RUN on start.
  - RUN -> FLUSH after the MAP_W*MAP_H-th accepted beat.
  - FLUSH -> DONE once the pipeline is empty (2 cycles).
  - DONE -> IDLE after 1 cycle, with done=1.
- start is ignored outside IDLE. in_valid is ignored outside RUN.
- Stage 1, per channel:
  - if relu_en and the value is negative, set it to 0;
  - arithmetic shift right by FRAC_SHIFT, truncating toward minus infinity;
  - saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Counters col (0..MAP_W-1) and row (0..MAP_H-1) advance on each accepted beat. col wraps to 0 and increments row.
- Pass-through (pool_en=0): each beat is written at addr = row*MAP_W+col.
- Pool (pool_en=1):
  - even col: hold the stage-1 value in a horizontal-max register;
  - odd col: h = max(held, current);
  - even row: store h into line buffer entry col/2 (MAP_W/2 entries per channel);
  - odd row: write max(linebuf[col/2], h) at addr (row/2)*(MAP_W/2)+col/2.
- Comparisons are signed, performed per channel independently.
- Mode and counters are not affected by in_valid gaps.

## Timing
- Reset values: out_wren=0, out_addr=0, out_data=0, busy=0, done=0. State returns to IDLE and counters and line buffer valid flags clear.
- Write latency is exactly 2 cycles from the accepted in_valid beat to out_wren, in both modes: stage-1 register, then write register.
- out_wren is high for one cycle per write, with out_addr and out_data valid in the same cycle.
- Write counts per frame:
  - pass-through: MAP_W*MAP_H writes, addresses 0..MAP_W*MAP_H-1 in order;
  - pool: MAP_W*MAP_H/4 writes.
- done is high in the cycle after the final out_wren. busy falls in the same cycle that done rises.
- A new start may be given in the cycle after done.
- Reset asserted mid-frame aborts immediately; no partial write completes after reset assertion.

## Structure
- The shared package cnn_pkg holds:
  - pool mode constants (POOL_NONE=0, POOL_MAX2=1);
  - the state encoding (IDLE, RUN, FLUSH, DONE);
  - a saturate/requantise function parameterised by widths.
- One sub-module, relu_quant: the per-channel stage-1 ReLU, shift and saturate with its output register, instantiated NUM_CH times in a generate loop.
- Line buffer: plain registers (MAP_W/2 x NUM_CH x DATA_WIDTH).

## Test plan
All scenarios use NUM_CH=2, MAP_W=MAP_H=4, FRAC_SHIFT=8, DATA_WIDTH=16.
- Reset: drive reset=0 with random inputs -> all outputs 0. start pulses with reset low have no effect.
- Pass-through, relu_en=1:
  - stimulus: ch0 = -512 every beat; ch1 = 256*i on beat i;
  - response: 16 writes at addr 0..15 with ch0=0 and ch1=i, each 2 cycles after its beat;
  - done one cycle after the write at addr 15.
- Saturation, relu_en=0:
  - ch0=0x7FFFFF00 -> 0x7FFF;
  - ch1=-0x01000000 -> 0x8000;
  - ch1=-1 -> 0xFFFF (floor).
- Pool, relu_en=1:
  - stimulus: ch0 = 256*(r*4+c); ch1 = -256*(r*4+c);
  - response: exactly 4 writes at addr 0..3 with ch0 = 5, 7, 13, 15 and ch1 = 0.
- Gaps and stray start: in_valid held low for 3 cycles between beats, plus a start pulse mid-frame -> identical outputs to the gap-free run, with latency measured per beat.
- Abort: reset low after 5 beats -> outputs 0 and busy 0 immediately. A fresh start afterwards reproduces the full pass-through result.
